// File: rtl/kb_pkg.sv
// kb_pkg: shared types and constants for the PS/2 key event controller.
// Holds the prefix FSM state enum, prefix byte values, event-word bit
// positions, register offsets and STATUS register bit positions.
package kb_pkg;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kb_state_t;
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam int EV_W   = 10;
    localparam int EV_EXT = 8;
    localparam int EV_BRK = 9;
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;
    localparam int DATA_VALID = 31;
    localparam int ST_CNT_W   = 7;
    localparam int ST_EMPTY   = 8;
    localparam int ST_FULL    = 9;
    localparam int ST_OVF     = 10;
endpackage

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: DEPTH-entry FIFO of key event words.
// Ports: clk, reset (async, active-high), push/din (write), pop (read head),
// clr (synchronous flush, wins over push/pop), dout (head word),
// full, empty, count (0..DEPTH).
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic                clr,
    input  logic [EV_W-1:0]     din,
    output logic [EV_W-1:0]     dout,
    output logic                full,
    output logic                empty,
    output logic [ST_CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [EV_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign full    = count == ST_CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + ST_CNT_W'(do_push) - ST_CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/key_event_controller.sv
// key_event_controller: turns PS/2 scan bytes into key events queued for a CPU.
// Ports: clk, reset (async, active-high), kb_valid/kb_code (scan byte strobe),
// rd_en/rd_adr (CPU read: 0 = DATA pops, 1 = STATUS), clr (flush),
// rd_data (combinational), key_pending (FIFO non-empty), overflow (sticky).
// Build option: define KEY_BREAK_FILTER_EN to discard break (key release) events.
module key_event_controller
    import kb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kb_valid,
    input  logic [7:0]  kb_code,
    input  logic        rd_en,
    input  logic        rd_adr,
    input  logic        clr,
    output logic [31:0] rd_data,
    output logic        key_pending,
    output logic        overflow
);
    kb_state_t state, state_nxt;
    logic                ev_form, keep, push, pop, full, empty, brk, ext;
    logic [EV_W-1:0]     ev_word, dout;
    logic [ST_CNT_W-1:0] count;

    assign brk     = (state == BRK) | (state == EXT_BRK);
    assign ext     = (state == EXT) | (state == EXT_BRK);
    assign ev_word = {brk, ext, kb_code};
`ifdef KEY_BREAK_FILTER_EN
    assign keep = ~brk;
`else
    assign keep = 1'b1;
`endif
    assign push        = ev_form & keep;
    assign pop         = rd_en & (rd_adr == REG_DATA);
    assign key_pending = ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else if (clr) state <= IDLE;
        else state <= state_nxt;
    end

    // Prefix bytes only move the FSM; a repeated prefix after F0 is ignored.
    always_comb begin
        state_nxt = state;
        ev_form   = 1'b0;
        if (kb_valid) begin
            if (kb_code == PREFIX_EXT) begin
                state_nxt = (state == IDLE) ? EXT : state;
            end else if (kb_code == PREFIX_BRK) begin
                state_nxt = (state == IDLE) ? BRK : (state == EXT) ? EXT_BRK : state;
            end else begin
                ev_form   = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // Full implies non-empty, so a DATA read is always a real pop here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else if (clr) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

    always_comb begin
        rd_data = '0;
        if (rd_adr == REG_STATUS) begin
            rd_data[ST_CNT_W-1:0] = count;
            rd_data[ST_EMPTY]     = empty;
            rd_data[ST_FULL]      = full;
            rd_data[ST_OVF]       = overflow;
        end else if (!empty) begin
            rd_data[DATA_VALID]   = 1'b1;
            rd_data[EV_W-1:0]     = dout;
        end
    end

    kb_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (ev_word),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_key_event_controller.sv
// tb_key_event_controller: self-checking bench for key_event_controller.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_key_event_controller;
    localparam int DEPTH = 8;
`ifdef KEY_BREAK_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, kb_valid = 1'b0, rd_en = 1'b0, rd_adr = 1'b0, clr = 1'b0;
    logic [7:0]  kb_code = 8'h00;
    logic [31:0] rd_data;
    logic        key_pending, overflow;

    int n_chk = 0, n_fail = 0;

    logic [9:0] q [$];
    bit m_ovf, m_ext, m_brk;

    key_event_controller #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .kb_valid    (kb_valid),
        .kb_code     (kb_code),
        .rd_en       (rd_en),
        .rd_adr      (rd_adr),
        .clr         (clr),
        .rd_data     (rd_data),
        .key_pending (key_pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic void m_step(input bit kv, input logic [7:0] code, input bit re, input bit ra, input bit cl);
        logic [9:0] ev;
        if (cl) begin
            q.delete();
            m_ovf = 0; m_ext = 0; m_brk = 0;
            return;
        end
        if (re && !ra && q.size() > 0) void'(q.pop_front());
        if (kv) begin
            if (code == 8'hE0) begin
                if (!m_brk) m_ext = 1;
            end else if (code == 8'hF0) begin
                m_brk = 1;
            end else begin
                ev = {m_brk, m_ext, code};
                m_ext = 0; m_brk = 0;
                if (!(FILT && ev[9])) begin
                    if (q.size() < DEPTH) q.push_back(ev);
                    else m_ovf = 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_data();
        return (q.size() == 0) ? 32'h0 : {1'b1, 21'b0, q[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[6:0] = 7'(q.size());
        s[8]   = q.size() == 0;
        s[9]   = q.size() == DEPTH;
        s[10]  = m_ovf;
        return s;
    endfunction

    task automatic drive(input bit kv, input logic [7:0] code, input bit re, input bit ra, input bit cl);
        kb_valid = kv; kb_code = code; rd_en = re; rd_adr = ra; clr = cl;
        @(posedge clk);
        m_step(kv, code, re, ra, cl);
        @(negedge clk);
        kb_valid = 0; rd_en = 0; clr = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        #2;
        q.delete();
        m_ovf = 0; m_ext = 0; m_brk = 0;
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        pulse_reset();
        n_chk++; if (key_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", key_pending); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", rd_data); end
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h100) begin n_fail++; $display("FAIL reset_status: got %h expected 00000100", rd_data); end
    endtask

    task automatic test_single();
        drive(1, 8'h1C, 0, 0, 0);
        n_chk++; if (key_pending !== 1'b1) begin n_fail++; $display("FAIL single_pending: got %b expected 1", key_pending); end
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h8000001C) begin n_fail++; $display("FAIL single_data: got %h expected 8000001c", rd_data); end
        drive(0, 8'h00, 1, 0, 0);
        n_chk++; if (key_pending !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %b expected 0", key_pending); end
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h100) begin n_fail++; $display("FAIL single_status: got %h expected 00000100", rd_data); end
    endtask

    task automatic test_prefix();
        drive(1, 8'hE0, 0, 0, 0);
        drive(1, 8'hF0, 0, 0, 0);
        n_chk++; if (key_pending !== 1'b0) begin n_fail++; $display("FAIL prefix_not_pushed: got %b expected 0", key_pending); end
        drive(1, 8'h75, 0, 0, 0);
        rd_adr = 0; #1;
        if (FILT) begin
            n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL prefix_filtered: got %h expected 00000000", rd_data); end
        end else begin
            n_chk++; if (rd_data !== 32'h80000375) begin n_fail++; $display("FAIL prefix_ext_brk: got %h expected 80000375", rd_data); end
        end
        drive(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) drive(1, 8'h10 + 8'(i), 0, 0, 0);
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h608) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000608", rd_data); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            rd_adr = 0; #1;
            n_chk++; if (rd_data !== (32'h80000010 + 32'(i))) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, rd_data, 32'h80000010 + 32'(i)); end
            drive(0, 8'h00, 1, 0, 0);
        end
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h500) begin n_fail++; $display("FAIL ovf_sticky: got %h expected 00000500", rd_data); end
        drive(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 8; i++) drive(1, 8'h20 + 8'(i), 0, 0, 0);
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h208) begin n_fail++; $display("FAIL full_status: got %h expected 00000208", rd_data); end
        drive(1, 8'h55, 1, 0, 0);
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h208) begin n_fail++; $display("FAIL pushpop_status: got %h expected 00000208", rd_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_overflow: got %b expected 0", overflow); end
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h80000021) begin n_fail++; $display("FAIL pushpop_head: got %h expected 80000021", rd_data); end
        for (int i = 0; i < 7; i++) drive(0, 8'h00, 1, 0, 0);
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h80000055) begin n_fail++; $display("FAIL pushpop_tail: got %h expected 80000055", rd_data); end
        drive(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        drive(1, 8'hE0, 0, 0, 0);
        pulse_reset();
        drive(1, 8'h1C, 0, 0, 0);
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h8000001C) begin n_fail++; $display("FAIL reset_mid_data: got %h expected 8000001c", rd_data); end
        drive(0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_clr_overflow();
        for (int i = 0; i < 9; i++) drive(1, 8'h30 + 8'(i), 0, 0, 0);
        drive(1, 8'hE0, 0, 0, 0);
        drive(1, 8'h33, 1, 0, 1);
        rd_adr = 1; #1;
        n_chk++; if (rd_data !== 32'h100) begin n_fail++; $display("FAIL clr_status: got %h expected 00000100", rd_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        drive(1, 8'h1C, 0, 0, 0);
        rd_adr = 0; #1;
        n_chk++; if (rd_data !== 32'h8000001C) begin n_fail++; $display("FAIL clr_fsm_idle: got %h expected 8000001c", rd_data); end
        drive(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_random();
        bit kv, re, ra, cl;
        logic [7:0] code;
        int r;
        for (int it = 0; it < 400; it++) begin
            kv = ($urandom % 3) != 0;
            r = $urandom % 8;
            code = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            re = ($urandom % 3) == 0;
            ra = $urandom % 2;
            cl = ($urandom % 40) == 0;
            drive(kv, code, re, ra, cl);
            rd_adr = 0; #1;
            n_chk++; if (rd_data !== exp_data()) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", it, rd_data, exp_data()); end
            rd_adr = 1; #1;
            n_chk++; if (rd_data !== exp_status()) begin n_fail++; $display("FAIL rand_status[%0d]: got %h expected %h", it, rd_data, exp_status()); end
            n_chk++; if (key_pending !== (q.size() != 0) || overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_flags[%0d]: got pending=%b ovf=%b expected pending=%b ovf=%b", it, key_pending, overflow, q.size() != 0, m_ovf);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_prefix();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_clr_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_event_controller.md
KEY_EVENT_CONTROLLER -- requirements
Module: key_event_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port kb_valid  input  1  one-cycle strobe: new PS/2 scan byte on kb_code.
REQ-005 SHALL have port kb_code  input  8  scan byte from keyboard decoder.
REQ-006 SHALL have port rd_en  input  1  CPU read strobe (IO-decoder select AND read).
REQ-007 SHALL have port rd_adr  input  1  register select: 0 = DATA (pop), 1 = STATUS.
REQ-008 SHALL have port clr  input  1  CPU flush strobe (IO-decoder select AND write).
REQ-009 SHALL have port rd_data  output  32  combinational read data.
REQ-010 SHALL have port key_pending  output  1  high when FIFO non-empty.
REQ-011 SHALL have port overflow  output  1  sticky lost-event flag.

Function
REQ-012 Prefix FSM SHALL have states IDLE, EXT, BRK, EXT_BRK; advances only on kb_valid.
REQ-013 Transitions: IDLE: E0->EXT, F0->BRK; EXT: F0->EXT_BRK, E0->EXT; BRK/EXT_BRK: E0/F0 ignored (stay); any other byte in any state -> event formed, next state IDLE.
REQ-014 Prefix bytes E0/F0 SHALL never be pushed.
REQ-015 Event word SHALL be {break, ext, code[7:0]}: break=1 from BRK/EXT_BRK, ext=1 from EXT/EXT_BRK.
REQ-016 Event SHALL be pushed in the cycle after the kb_valid completing it (1-cycle latency to key_pending).
REQ-017 DATA read (rd_adr=0): rd_data = {valid, 21'b0, break, ext, code} of head; valid=1 if non-empty; all-zero if empty.
REQ-018 rd_en with rd_adr=0 and non-empty SHALL pop head at clock edge; read when empty SHALL not change state.
REQ-019 STATUS read (rd_adr=1): bits[6:0] count, bit8 empty, bit9 full, bit10 overflow, rest 0; STATUS read SHALL not pop or clear.
REQ-020 Push when full without same-cycle pop SHALL drop the event and set overflow.
REQ-021 Push and pop in same cycle SHALL both occur, count unchanged, including when full.
REQ-022 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 clr SHALL empty FIFO, clear overflow, return FSM to IDLE next edge; clr wins over simultaneous push/pop.
REQ-024 overflow SHALL remain set until clr or reset.

Reset
REQ-025 Reset SHALL asynchronously force FSM=IDLE, pointers=0, count=0, overflow=0, key_pending=0.
REQ-026 Reset mid-sequence (e.g. after E0) SHALL discard the partial prefix; FIFO contents lost.
REQ-027 rd_data after reset SHALL read 0 at DATA, 0x100 at STATUS.

Configuration
REQ-028 Macro KEY_BREAK_FILTER_EN defined: break events (break=1) SHALL be discarded, not pushed, never set overflow.
REQ-029 Macro undefined: break events SHALL be pushed as in REQ-015.

Structure
REQ-030 Package kb_pkg SHALL hold FSM state enum, PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, event-word bit positions, register offsets, STATUS bit positions.
REQ-031 FIFO storage/pointers SHALL be sub-module kb_event_fifo (push, pop, clr, full, empty, count); FSM and register map stay in key_event_controller.

Verification
REQ-032 Reset, bytes 1C -> key_pending=1 after 1 cycle; DATA read = 0x8000001C; then empty, STATUS=0x100.
REQ-033 Bytes E0,F0,75 (filter off) -> DATA = 0x80000375; with KEY_BREAK_FILTER_EN -> FIFO stays empty.
REQ-034 Push 9 events (DEPTH=8), no reads -> STATUS=0x608 (count 8, full, overflow); first 8 codes read in order; 9th lost.
REQ-035 Full FIFO, simultaneous push and DATA pop -> count stays 8, overflow stays 0, new code at tail.
REQ-036 Bytes E0 then reset pulse, then 1C -> DATA = 0x8000001C (ext=0).
REQ-037 Overflow set, clr asserted same cycle as a push -> STATUS=0x100 next cycle, FSM IDLE.
